// File: rtl/perm_rank_pkg.sv
// Shared types and constant helpers for the sequential permutation ranker.
// Rank width derives from N! so downstream tables size themselves from the same function.
package perm_rank_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  function automatic longint unsigned fact(input int unsigned n);
    longint unsigned f;
    f = 1;
    for (int unsigned i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  function automatic int unsigned rank_width(input int unsigned n);
    return $clog2(fact(n));
  endfunction

  // Width of one permutation element; the element type is logic [elem_width(N)-1:0].
  function automatic int unsigned elem_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/perm_rank_seq_if.sv
// Handshake bundle between the permutation generator, the ranker and the config table.
interface perm_rank_seq_if
  import perm_rank_pkg::*;
#(
  parameter int unsigned N = 6
);
  localparam int unsigned W  = elem_width(N);
  localparam int unsigned RW = rank_width(N);

  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] prm;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] enm;
  logic          err;

  modport master (
    output in_valid, prm, out_ready,
    input  in_ready, out_valid, enm, err
  );

  modport slave (
    input  in_valid, prm, out_ready,
    output in_ready, out_valid, enm, err
  );

endinterface

// File: rtl/perm_rank_cnt.sv
// Lehmer digit for one position: count of later elements smaller than element k.
// With PERM_RANK_CHECK_EN it also flags an out-of-range or later-duplicated element k.
module perm_rank_cnt
  import perm_rank_pkg::*;
#(
  parameter int unsigned N = 6,
  localparam int unsigned W  = elem_width(N),
  localparam int unsigned KW = $clog2(N + 1)
) (
  input  logic [N*W-1:0] prm,
  input  logic [KW-1:0]  k,
  output logic [W:0]     c
`ifdef PERM_RANK_CHECK_EN
  ,
  output logic           hit
`endif
);

  typedef logic [W-1:0] elem_t;
  elem_t pk;

  always_comb begin
    pk = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (KW'(i) == k) pk = prm[i*W +: W];
    end
    c = '0;
`ifdef PERM_RANK_CHECK_EN
    hit = (32'(pk) >= N);
`endif
    for (int j = 0; j < int'(N); j++) begin
      if (KW'(j) > k) begin
        if (prm[j*W +: W] < pk) c = c + 1'b1;
`ifdef PERM_RANK_CHECK_EN
        if (prm[j*W +: W] == pk) hit = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/perm_rank_seq.sv
// Sequential Lehmer ranker: one position per clock, Horner accumulation of digits.
// Optional malformed-permutation flag is built when PERM_RANK_CHECK_EN is defined.
module perm_rank_seq
  import perm_rank_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  perm_rank_seq_if.slave bus
);

  localparam int unsigned W  = elem_width(N);
  localparam int unsigned RW = rank_width(N);
  localparam int unsigned KW = $clog2(N + 1);

  state_e         state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [RW-1:0]  enm_q;
  logic [RW-1:0]  acc_q;
  logic [RW-1:0]  acc_next;
  logic [KW-1:0]  k_q;
  logic [N*W-1:0] prm_q;
  logic [W:0]     c_k;
`ifdef PERM_RANK_CHECK_EN
  logic           hit;
  logic           bad_q;
  logic           err_q;
`endif

  perm_rank_cnt #(
    .N (N)
  ) u_cnt (
    .prm (prm_q),
    .k   (k_q),
    .c   (c_k)
`ifdef PERM_RANK_CHECK_EN
    ,
    .hit (hit)
`endif
  );

  // At k=0 acc is zero, so a factor truncated to RW bits (N=2) is harmless.
  assign acc_next = RW'(acc_q * RW'(N - 32'(k_q))) + RW'(c_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      enm_q       <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      prm_q       <= '0;
`ifdef PERM_RANK_CHECK_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            state_q    <= StCalc;
            in_ready_q <= 1'b0;
            prm_q      <= bus.prm;
            k_q        <= '0;
            acc_q      <= '0;
`ifdef PERM_RANK_CHECK_EN
            bad_q      <= 1'b0;
`endif
          end
        end
        StCalc: begin
          // k == N is the commit cycle that registers the finished rank.
          if (k_q == KW'(N)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
`ifdef PERM_RANK_CHECK_EN
            enm_q       <= bad_q ? '0 : acc_q;
            err_q       <= bad_q;
`else
            enm_q       <= acc_q;
`endif
          end else begin
            acc_q <= acc_next;
            k_q   <= k_q + 1'b1;
`ifdef PERM_RANK_CHECK_EN
            bad_q <= bad_q | hit;
`endif
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.enm       = enm_q;
`ifdef PERM_RANK_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_perm_rank_seq.sv
// Directed bench for perm_rank_seq: table of hand-ranked permutations on N=6/4/3 instances,
// an N=4 full lexicographic sweep, backpressure, mid-calculation reset and malformed inputs.
module tb_perm_rank_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  perm_rank_seq_if #(.N(6)) if6 ();
  perm_rank_seq_if #(.N(4)) if4 ();
  perm_rank_seq_if #(.N(3)) if3 ();

  perm_rank_seq #(.N(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6));
  perm_rank_seq #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  perm_rank_seq #(.N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          n;
    logic [31:0] el;    // element i in nibble i
    int unsigned rank;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pack(input int n, input logic [31:0] el);
    logic [23:0] r;
    int w;
    w = (n <= 2) ? 1 : (n <= 4) ? 2 : 3;
    r = '0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < w; b++) r[i*w+b] = el[i*4+b];
    return r;
  endfunction

  function automatic logic get_rdy(input int n);
    case (n)
      6:       return if6.in_ready;
      4:       return if4.in_ready;
      default: return if3.in_ready;
    endcase
  endfunction

  function automatic logic get_ov(input int n);
    case (n)
      6:       return if6.out_valid;
      4:       return if4.out_valid;
      default: return if3.out_valid;
    endcase
  endfunction

  function automatic int unsigned get_enm(input int n);
    case (n)
      6:       return 32'(if6.enm);
      4:       return 32'(if4.enm);
      default: return 32'(if3.enm);
    endcase
  endfunction

  function automatic logic get_err(input int n);
    case (n)
      6:       return if6.err;
      4:       return if4.err;
      default: return if3.err;
    endcase
  endfunction

  task automatic set_in(input int n, input logic v, input logic [23:0] p);
    case (n)
      6:       begin if6.in_valid = v; if6.prm = p[17:0]; end
      4:       begin if4.in_valid = v; if4.prm = p[7:0];  end
      default: begin if3.in_valid = v; if3.prm = p[5:0];  end
    endcase
  endtask

  // Offer p, return once out_valid is seen; lat counts clocks from the accepting edge.
  task automatic xact(input int n, input logic [23:0] p, output int unsigned r, output logic e,
                      output int lat, output logic to);
    int g;
    g  = 0;
    to = 1'b0;
    while (!get_rdy(n) && g < 50) begin
      tick();
      g++;
    end
    if (!get_rdy(n)) to = 1'b1;
    set_in(n, 1'b1, p);
    tick();
    set_in(n, 1'b0, p);
    lat = 0;
    while (!get_ov(n) && lat < 50) begin
      tick();
      lat++;
    end
    if (!get_ov(n)) to = 1'b1;
    r = get_enm(n);
    e = get_err(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    logic        e;
    int          lat;
    logic        to;
    int          idx;

    vecs[0] = '{6, 32'h0054_3210, 0};
    vecs[1] = '{6, 32'h0001_2345, 719};
    vecs[2] = '{4, 32'h0000_2301, 7};
    vecs[3] = '{3, 32'h0000_0102, 4};
    vecs[4] = '{6, 32'h0054_3201, 120};
    vecs[5] = '{6, 32'h0045_3210, 1};
    vecs[6] = '{6, 32'h0043_2105, 600};
    vecs[7] = '{6, 32'h0031_5042, 316};
    vecs[8] = '{3, 32'h0000_0012, 5};
    vecs[9] = '{4, 32'h0000_0123, 23};

    set_in(6, 1'b0, '0);
    set_in(4, 1'b0, '0);
    set_in(3, 1'b0, '0);
    if6.out_ready = 1'b1;
    if4.out_ready = 1'b1;
    if3.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", get_rdy(6), 0);
    chk("rst_out_valid", get_ov(6), 0);
    chk("rst_enm", get_enm(6), 0);
    chk("rst_err", get_err(6), 0);
    tick();
    rst_n = 1'b1;
    chk("rst_hold_ready", get_rdy(6), 0);
    tick();
    chk("idle_in_ready6", get_rdy(6), 1);
    chk("idle_in_ready4", get_rdy(4), 1);

    // Table of hand-ranked permutations
    for (int i = 0; i < 10; i++) begin
      xact(vecs[i].n, pack(vecs[i].n, vecs[i].el), r, e, lat, to);
      chk($sformatf("vec%0d_timeout", i), to, 0);
      chk($sformatf("vec%0d_enm", i), r, vecs[i].rank);
      chk($sformatf("vec%0d_err", i), e, 0);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].n + 1);
      chk($sformatf("vec%0d_done_ready", i), get_rdy(vecs[i].n), 0);
      tick();
      chk($sformatf("vec%0d_back_idle", i), get_ov(vecs[i].n), 0);
    end

    // All 24 permutations of N=4 in lexicographic order rank 0..23
    idx = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++) begin
            if (a != b && a != c && a != d && b != c && b != d && c != d) begin
              xact(4, pack(4, 32'(a) | (32'(b) << 4) | (32'(c) << 8) | (32'(d) << 12)),
                   r, e, lat, to);
              chk($sformatf("sweep%0d", idx), r, idx);
              tick();
              idx++;
            end
          end

    // Backpressure: result holds, a new prm during DONE is ignored
    if6.out_ready = 1'b0;
    xact(6, pack(6, 32'h0001_2345), r, e, lat, to);
    chk("bp_enm", r, 719);
    set_in(6, 1'b1, pack(6, 32'h0054_3210));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold_enm%0d", i), get_enm(6), 719);
      chk($sformatf("bp_hold_ready%0d", i), get_rdy(6), 0);
      chk($sformatf("bp_hold_valid%0d", i), get_ov(6), 1);
    end
    set_in(6, 1'b0, pack(6, 32'h0054_3210));
    if6.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", get_ov(6), 0);
    chk("bp_release_ready", get_rdy(6), 1);
    chk("bp_release_enm", get_enm(6), 719);
    tick();
    chk("bp_no_capture", get_ov(6), 0);

    // Reset at k=3 aborts; a fresh reverse permutation then ranks 719
    set_in(6, 1'b1, pack(6, 32'h0001_2345));
    tick();
    set_in(6, 1'b0, pack(6, 32'h0001_2345));
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", get_ov(6), 0);
    chk("midrst_enm", get_enm(6), 0);
    chk("midrst_ready", get_rdy(6), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_idle_ready", get_rdy(6), 1);
    xact(6, pack(6, 32'h0001_2345), r, e, lat, to);
    chk("midrst_fresh_enm", r, 719);
    chk("midrst_fresh_latency", lat, 7);
    tick();

    // Malformed permutations: duplicate, then out-of-range element
    xact(6, pack(6, 32'h0054_3110), r, e, lat, to);
    chk("dup_timeout", to, 0);
    chk("dup_latency", lat, 7);
`ifdef PERM_RANK_CHECK_EN
    chk("dup_err", e, 1);
    chk("dup_enm", r, 0);
`else
    chk("dup_err", e, 0);
`endif
    tick();
    xact(6, pack(6, 32'h0074_3210), r, e, lat, to);
    chk("range_timeout", to, 0);
`ifdef PERM_RANK_CHECK_EN
    chk("range_err", e, 1);
    chk("range_enm", r, 0);
`else
    chk("range_err", e, 0);
`endif
    tick();
    xact(6, pack(6, 32'h0031_5042), r, e, lat, to);
    chk("post_bad_enm", r, 316);
    chk("post_bad_err", e, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
